// File: rtl/cp0_unit_pkg.sv
// Shared CP0 constants: handler entry, register addresses, exception codes.
package cp0_unit_pkg;
    localparam logic [31:0] HANDLER  = 32'h0000_4180;
    localparam int          IM_W     = 6;

    localparam logic [4:0]  CP0_SR    = 5'd12;
    localparam logic [4:0]  CP0_CAUSE = 5'd13;
    localparam logic [4:0]  CP0_EPC   = 5'd14;
    localparam logic [4:0]  CP0_PRID  = 5'd15;

    localparam logic [4:0]  EXC_INT  = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;
    localparam logic [4:0]  EXC_SYS  = 5'd8;
    localparam logic [4:0]  EXC_RI   = 5'd10;
    localparam logic [4:0]  EXC_OV   = 5'd12;

    localparam logic [31:0] PRID_VAL = 32'h4255_4141;
endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 bundle: mtc0/mfc0 access, exception info down the pipe, req/EPC back.
interface cp0_unit_if;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output cp0_we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, eret,
        input  cp0_rdata, req, epc_out
    );
    modport slave (
        input  cp0_we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, eret,
        output cp0_rdata, req, epc_out
    );
endinterface

// File: rtl/cp0_req_gen.sv
// Combinational exception/interrupt arbiter; interrupts take priority over pipe exceptions.
module cp0_req_gen
    import cp0_unit_pkg::*;
#(
    parameter int IM_W = 6
) (
    input  logic            ie,
    input  logic            exl,
    input  logic [IM_W-1:0] im,
    input  logic [IM_W-1:0] hw_int,
    input  logic [4:0]      exc_code_in,
    output logic            req,
    output logic [4:0]      exc_sel
);
    logic int_req, exc_req;

    assign int_req = ie & ~exl & (|(hw_int & im));
    assign exc_req = (exc_code_in != EXC_INT) & ~exl;
    assign req     = int_req | exc_req;
    assign exc_sel = int_req ? EXC_INT : exc_code_in;
endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 (SR/Cause/EPC) for the M stage. Optional PRId register under CP0_PRID_EN.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter int IM_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IM_W-1:0] hw_int,
    cp0_unit_if.slave       bus
);
    logic [IM_W-1:0] im, ip;
    logic            exl, ie, bd;
    logic [4:0]      exc_code, exc_sel;
    logic [31:0]     epc, epc_next, sr_val, cause_val;
    logic            req;

    cp0_req_gen #(.IM_W(IM_W)) u_req_gen (
        .ie          (ie),
        .exl         (exl),
        .im          (im),
        .hw_int      (hw_int),
        .exc_code_in (bus.exc_code_in),
        .req         (req),
        .exc_sel     (exc_sel)
    );

    assign bus.req = req;
    // Delay-slot faults return to the branch so it is re-executed.
    assign epc_next = (bus.vpc & ~32'd3) - (bus.bd_in ? 32'd4 : 32'd0);

    always_comb begin
        sr_val              = '0;
        sr_val[10 +: IM_W]  = im;
        sr_val[1]           = exl;
        sr_val[0]           = ie;
        cause_val             = '0;
        cause_val[31]         = bd;
        cause_val[10 +: IM_W] = ip;
        cause_val[6:2]        = exc_code;
    end

    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_addr)
            CP0_SR:    bus.cp0_rdata = sr_val;
            CP0_CAUSE: bus.cp0_rdata = cause_val;
            CP0_EPC:   bus.cp0_rdata = epc;
`ifdef CP0_PRID_EN
            CP0_PRID:  bus.cp0_rdata = PRID_VAL;
`endif
            default:   bus.cp0_rdata = '0;
        endcase
    end

    // An mtc0 EPC still in M must be visible to an eret issuing behind it.
    assign bus.epc_out = (bus.cp0_we && bus.cp0_addr == CP0_EPC) ? bus.cp0_wdata : epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= hw_int;
            if (req) begin
                exl      <= 1'b1;
                exc_code <= exc_sel;
                bd       <= bus.bd_in;
                epc      <= epc_next;
            end else begin
                if (bus.eret)
                    exl <= 1'b0;
                if (bus.cp0_we) begin
                    case (bus.cp0_addr)
                        CP0_SR: begin
                            im  <= bus.cp0_wdata[10 +: IM_W];
                            exl <= bus.cp0_wdata[1];
                            ie  <= bus.cp0_wdata[0];
                        end
                        CP0_EPC: epc <= bus.cp0_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed plan plus random traffic vs a word-level model.
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] hw_int;

    cp0_unit_if bus();

    cp0_unit dut (
        .clk    (clk),
        .reset  (reset),
        .hw_int (hw_int),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_sr, m_cause, m_epc;
    bit          inited = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_int();
        return m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic bit m_req();
        return m_int() || (bus.exc_code_in != 5'd0 && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
`ifdef CP0_PRID_EN
            5'd15: return 32'h4255_4141;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                         input logic [5:0] hw, input logic er, input logic rst);
        bus.cp0_we      = we;
        bus.cp0_addr    = addr;
        bus.cp0_wdata   = wd;
        bus.vpc         = pc;
        bus.bd_in       = bd;
        bus.exc_code_in = exc;
        bus.eret        = er;
        hw_int          = hw;
        reset           = rst;
        #1;
    endtask

    task automatic idle(input logic [4:0] addr, input logic [5:0] hw);
        drive(1'b0, addr, 32'h0, 32'h0, 1'b0, 5'd0, hw, 1'b0, 1'b0);
    endtask

    // Check combinational outputs against the model, then clock and advance the model.
    task automatic tick();
        bit r, ir;
        logic [31:0] pc_al;
        r  = m_req();
        ir = m_int();
        if (inited) begin
            check("req", {31'b0, bus.req}, {31'b0, r});
            check("rdata", bus.cp0_rdata, m_read(bus.cp0_addr));
            check("epc_out", bus.epc_out,
                  (bus.cp0_we && bus.cp0_addr == 5'd14) ? bus.cp0_wdata : m_epc);
        end
        @(posedge clk);
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            m_cause[15:10] = hw_int;
            if (r) begin
                m_sr[1]       = 1'b1;
                m_cause[6:2]  = ir ? 5'd0 : bus.exc_code_in;
                m_cause[31]   = bus.bd_in;
                pc_al         = {bus.vpc[31:2], 2'b00};
                m_epc         = bus.bd_in ? pc_al - 32'd4 : pc_al;
            end else begin
                if (bus.eret) m_sr[1] = 1'b0;
                if (bus.cp0_we && bus.cp0_addr == 5'd12) m_sr = bus.cp0_wdata & 32'h0000_FC03;
                if (bus.cp0_we && bus.cp0_addr == 5'd14) m_epc = bus.cp0_wdata;
            end
        end
        inited = 1;
        #1;
    endtask

    initial begin
        logic [4:0] exc_tab [8];
        exc_tab = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        tick();
        idle(5'd12, 6'd0); check("rst_sr", bus.cp0_rdata, 32'h0); check("rst_req", {31'b0, bus.req}, 32'h0); tick();
        idle(5'd13, 6'd0); check("rst_cause", bus.cp0_rdata, 32'h0); tick();
        idle(5'd14, 6'd0); check("rst_epc", bus.cp0_rdata, 32'h0); tick();

        drive(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0); tick();
        idle(5'd13, 6'd1); check("int_req", {31'b0, bus.req}, 32'h1); tick();
        idle(5'd13, 6'd1); check("int_cause", bus.cp0_rdata, 32'h0000_0400); tick();
        idle(5'd12, 6'd1); check("int_exl", bus.cp0_rdata, 32'h0000_0403); tick();

        drive(1'b1, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 5'd14, 32'h0, 32'h0000_3010, 1'b1, 5'd12, 6'd0, 1'b0, 1'b0);
        check("ov_req", {31'b0, bus.req}, 32'h1); tick();
        idle(5'd14, 6'd0); check("ov_epc", bus.cp0_rdata, 32'h0000_300C); tick();
        idle(5'd13, 6'd0); check("ov_cause", bus.cp0_rdata, 32'h8000_0030); tick();

        drive(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 5'd13, 32'h0, 32'h0000_0100, 1'b0, 5'd10, 6'd1, 1'b0, 1'b0); tick();
        idle(5'd13, 6'd1); check("int_wins", bus.cp0_rdata, 32'h0000_0400); tick();

        drive(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 5'd4, 6'd1, 1'b0, 1'b0);
        check("exl_mask", {31'b0, bus.req}, 32'h0); tick();
        drive(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd1, 1'b1, 1'b0); tick();
        idle(5'd12, 6'd1); check("eret_pend", {31'b0, bus.req}, 32'h1); tick();

        drive(1'b1, 5'd14, 32'h0000_3400, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
        check("epc_byp", bus.epc_out, 32'h0000_3400); tick();

        drive(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd1, 1'b0, 1'b0); tick();
        idle(5'd12, 6'd0); check("sr_drop", bus.cp0_rdata, 32'h0000_0403); tick();

        drive(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd1, 1'b0, 1'b1); tick();
        idle(5'd12, 6'd1); check("rst_pend", {31'b0, bus.req}, 32'h0); check("rst_pend_sr", bus.cp0_rdata, 32'h0); tick();

        idle(5'd15, 6'd0);
`ifdef CP0_PRID_EN
        check("prid", bus.cp0_rdata, 32'h4255_4141);
`else
        check("prid", bus.cp0_rdata, 32'h0);
`endif
        tick();

        for (int i = 0; i < 600; i++) begin
            logic [4:0] a;
            case ($urandom_range(0, 4))
                0: a = 5'd12;
                1: a = 5'd13;
                2: a = 5'd14;
                3: a = 5'd15;
                default: a = 5'($urandom);
            endcase
            drive($urandom_range(0, 3) == 0, a, $urandom, $urandom, 1'($urandom),
                  exc_tab[$urandom_range(0, 7)],
                  ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline, instantiated in the M stage.
- Holds SR, Cause and EPC, and arbitrates hardware interrupts against the exception code carried down the pipe.
- Drives Req, which flushes the M/W pipeline register (that register loads NOP and PC=HANDLER) and redirects fetch to the handler.
- Serves mfc0 reads (CP0out_M) and mtc0 writes, and supplies EPC for eret.

Parameters:
- HANDLER, 32'h0000_4180, exception entry PC (mirrors the shared constant).
- IM_W, 6, number of hardware interrupt lines.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cp0_we  in  1  mtc0 write enable (M-stage instr is mtc0)
- cp0_addr  in  5  rd field of mtc0/mfc0
- cp0_wdata  in  32  forwarded rt value for mtc0
- cp0_rdata  out  32  mfc0 read data (feeds CP0out_M)
- vpc  in  32  PC of the M-stage instruction
- bd_in  in  1  M-stage instr sits in a branch delay slot
- exc_code_in  in  5  pipelined exception code; 0 = none
- hw_int  in  IM_W  external interrupt lines, level-sensitive
- eret  in  1  M-stage instr is eret
- req  out  1  take exception/interrupt this cycle
- epc_out  out  32  return PC for eret (bypassed)

Behaviour:
- Registers: SR (addr 12), Cause (addr 13), EPC (addr 14).
- SR fields: IM[15:10], EXL[1], IE[0]. All other SR bits are stored as 0 and read as 0.
- Cause fields: BD[31], IP[15:10], ExcCode[6:2]. All other Cause bits read 0.
- Reset: SR, Cause and EPC all clear to 0 in the cycle reset is high. No outputs are registered beyond these registers.
- int_req = IE & ~EXL & |(hw_int & IM).
- exc_req = (exc_code_in != 0) & ~EXL.
- req = int_req | exc_req. This is combinational, same cycle, zero latency.
- Priority: an interrupt wins over an exception.
- On a clock edge with req=1:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= bd_in ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}.
- Cause.IP <= hw_int on every non-reset edge, regardless of req or EXL.
- eret with req=0: EXL <= 0 on that edge.
- eret with req=1: eret is ignored.
- mtc0 (cp0_we=1, req=0):
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes EPC with the full 32 bits.
  - addr 13 and other addresses are ignored.
- mtc0 with req=1: the write is dropped, because the instruction is flushed.
- cp0_rdata: combinational read of the addressed register. Unmapped addresses read 0. There is no write-then-read bypass inside the same cycle.
- epc_out = (cp0_we & cp0_addr==14) ? cp0_wdata : EPC. This covers an mtc0 EPC in M followed by eret in the same cycle window.
- Nested events: while EXL=1, no req is generated for either interrupts or exceptions.
- Reset during pending req: reset wins, registers clear, and req falls once SR is cleared.

Optional Feature:
- Macro: CP0_PRID_EN.
- Defined:
  - adds a read-only PRId register at addr 15, returning constant 32'h4255_4141;
  - mtc0 to addr 15 is ignored.
- Undefined: addr 15 reads 0 and no PRId logic exists.

Decomposition:
- Shared param.v holds:
  - `HANDLER;
  - CP0 register addresses: SR=12, CAUSE=13, EPC=14, PRID=15;
  - ExcCode values: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
- One natural sub-module: cp0_req_gen. It is combinational and computes int_req, exc_req, req and the selected ExcCode from SR and the inputs.

Test Plan:
- Reset, then mfc0 of addrs 12/13/14 -> all read 32'h0, req=0.
- mtc0 SR=32'h0000_0401, then hw_int=6'b000001 -> req=1 same cycle; next edge Cause=32'h0000_0400 (ExcCode 0, IP[10]=1), EXL=1.
- exc_code_in=12 (Ov), vpc=32'h0000_3010, bd_in=1, SR.EXL=0 -> req=1; after edge EPC=32'h0000_300C, Cause[31]=1, Cause[6:2]=12.
- Simultaneous: IE=1, IM matching, hw_int active, and exc_code_in=10 -> ExcCode recorded 0 (interrupt wins).
- EXL=1 with exc_code_in=4 and active interrupt -> req=0. Then eret -> EXL=0 after the edge, and the pending interrupt raises req the next cycle.
- mtc0 EPC=32'h0000_3400 with eret in the same cycle -> epc_out=32'h0000_3400 that cycle. mtc0 SR with req=1 -> SR unchanged apart from EXL set.
